// File: rtl/uart_baud_gen_mc.sv
// uart_baud_gen_mc -- multi-channel UART baud tick generator.
//
// Each channel divides the system clock by (shadow_val+1) cycles and adds one
// extra cycle every time a fractional accumulator carries. The average tick
// period is therefore (shadow_val+1) + shadow_frac/2^FRAC_W cycles. Every tick
// advances an oversample counter; the tick that closes an OVS-long run is also
// flagged as a bit-rate (xmit) tick.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset; clears all state
//   enable     per-channel run enable; low freezes the divider state
//   cfg_load   per-channel strobe capturing baud_val/baud_frac into the shadow
//   baud_val   per-channel integer divisor, channel i at [i*CNT_W +: CNT_W]
//   baud_frac  per-channel fractional divisor, channel i at [i*FRAC_W +: FRAC_W]
//   sync_clr   per-channel synchronous restart (priority over enable)
//   baud_tick  registered one-cycle oversample pulse per channel
//   xmit_tick  one-cycle bit pulse, coincident with every OVS-th baud_tick
//   ovs_phase  oversample count per channel, 4 bits each, zero-extended
module uart_baud_gen_mc #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 13,
  parameter int FRAC_W = 3,
  parameter int OVS    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        enable,
  input  logic [NUM_CH-1:0]        cfg_load,
  input  logic [NUM_CH*CNT_W-1:0]  baud_val,
  input  logic [NUM_CH*FRAC_W-1:0] baud_frac,
  input  logic [NUM_CH-1:0]        sync_clr,
  output logic [NUM_CH-1:0]        baud_tick,
  output logic [NUM_CH-1:0]        xmit_tick,
  output logic [NUM_CH*4-1:0]      ovs_phase
);

  localparam logic [3:0]       OVS_LAST = 4'(OVS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Accumulator step: the MSB of the result is the carry that requests the
  // extra (stall) cycle; the low bits wrap modulo 2^FRAC_W.
  function automatic logic [FRAC_W:0] frac_step(input logic [FRAC_W-1:0] acc_in,
                                                input logic [FRAC_W-1:0] frac_in);
    return {1'b0, acc_in} + {1'b0, frac_in};
  endfunction

  // Oversample counter step with wrap at an arbitrary (non power-of-two) OVS.
  function automatic logic [3:0] ovs_step(input logic [3:0] cnt_in);
    return (cnt_in == OVS_LAST) ? 4'd0 : cnt_in + 4'd1;
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0]  cntr;
    logic [CNT_W-1:0]  shadow_val;
    logic [FRAC_W-1:0] shadow_frac;
    logic [FRAC_W-1:0] acc;
    logic              stall_pend;
    logic [3:0]        ovs_cnt;
    logic              tick_r;
    logic [FRAC_W:0]   acc_sum;

    assign acc_sum = frac_step(acc, shadow_frac);

    // Divider stage: counter, fractional stall and registered tick.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cntr        <= '0;
        shadow_val  <= '0;
        shadow_frac <= '0;
        acc         <= '0;
        stall_pend  <= 1'b0;
        ovs_cnt     <= '0;
        tick_r      <= 1'b0;
      end else begin
        // The shadow is only read at reload, so a running period always
        // finishes with the divisor it started with.
        if (cfg_load[i]) begin
          shadow_val  <= baud_val[i*CNT_W +: CNT_W];
          shadow_frac <= baud_frac[i*FRAC_W +: FRAC_W];
        end

        if (sync_clr[i]) begin
          cntr       <= '0;
          acc        <= '0;
          stall_pend <= 1'b0;
          ovs_cnt    <= '0;
          tick_r     <= 1'b0;
        end else begin
          // ovs_cnt counts ticks that were actually emitted; a tick already on
          // the output is counted even if enable drops on this edge, so the
          // phase never repeats for two distinct ticks.
          if (tick_r) begin
            ovs_cnt <= ovs_step(ovs_cnt);
          end

          if (enable[i]) begin
            if (cntr != '0) begin
              cntr   <= cntr - CNT_ONE;
              tick_r <= 1'b0;
            end else if (stall_pend) begin
              // Fractional extension: hold at zero for one extra cycle.
              stall_pend <= 1'b0;
              tick_r     <= 1'b0;
            end else begin
              cntr                <= shadow_val;
              tick_r              <= 1'b1;
              {stall_pend, acc}   <= acc_sum;
            end
          end else begin
            tick_r <= 1'b0;
          end
        end
      end
    end

    // Output stage: decoded directly from registers.
    assign baud_tick[i]        = tick_r;
    assign xmit_tick[i]        = tick_r & (ovs_cnt == OVS_LAST);
    assign ovs_phase[i*4 +: 4] = ovs_cnt;
  end

endmodule

// File: tb/tb_uart_baud_gen_mc.sv
// Scoreboard bench for uart_baud_gen_mc (NUM_CH=2, CNT_W=13, FRAC_W=3, OVS=10).
// Stimulus pushes the expected gap (cycles since the previous tick or restart),
// oversample phase and xmit flag of every tick; a negedge monitor pops and
// compares whenever a channel presents baud_tick.
module tb_uart_baud_gen_mc;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 13;
  localparam int FRAC_W = 3;
  localparam int OVS    = 10;

  logic                     clk;
  logic                     reset;
  logic [NUM_CH-1:0]        enable;
  logic [NUM_CH-1:0]        cfg_load;
  logic [NUM_CH*CNT_W-1:0]  baud_val;
  logic [NUM_CH*FRAC_W-1:0] baud_frac;
  logic [NUM_CH-1:0]        sync_clr;
  logic [NUM_CH-1:0]        baud_tick;
  logic [NUM_CH-1:0]        xmit_tick;
  logic [NUM_CH*4-1:0]      ovs_phase;

  uart_baud_gen_mc #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .FRAC_W(FRAC_W), .OVS(OVS)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_load(cfg_load),
    .baud_val(baud_val), .baud_frac(baud_frac), .sync_clr(sync_clr),
    .baud_tick(baud_tick), .xmit_tick(xmit_tick), .ovs_phase(ovs_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int gap;
    int phase;
    bit xmit;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   ph[NUM_CH];
  int   last[NUM_CH];
  int   cyc;
  int   checks;
  int   errors;

  int gap_f4[9]  = '{1, 4, 5, 4, 5, 4, 5, 4, 5};
  int gap_f1[10] = '{1, 4, 4, 4, 4, 4, 4, 4, 5, 4};
  int gap_f7[10] = '{1, 4, 5, 5, 5, 5, 5, 5, 5, 4};
  int gap_ld[6]  = '{1, 10, 3, 3, 3, 3};
  int gap_en[5]  = '{1, 4, 11, 4, 4};
  int gap_c1[14] = '{1, 5, 5, 5, 6, 5, 5, 5, 6, 5, 5, 5, 6, 5};
  int gap_rl[7]  = '{1, 1, 1, 1, 1, 3, 3};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Edge counter and restart bookkeeping for gap measurement.
  initial begin
    cyc = 0;
    last[0] = 0;
    last[1] = 0;
    forever begin
      @(posedge clk);
      cyc++;
      for (int ch = 0; ch < NUM_CH; ch++)
        if (reset || sync_clr[ch]) last[ch] = cyc;
    end
  end

  // Monitor: pop and compare on every presented tick.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (baud_tick[ch]) begin
          if ((ch == 0 && q0.size() == 0) || (ch == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_tick ch%0d: got tick, expected none (cycle %0d)", ch, cyc);
          end else begin
            if (ch == 0) e = q0.pop_front();
            else         e = q1.pop_front();
            chk($sformatf("gap_ch%0d", ch), cyc - last[ch], e.gap);
            chk($sformatf("phase_ch%0d", ch), int'(ovs_phase[ch*4 +: 4]), e.phase);
            chk($sformatf("xmit_ch%0d", ch), int'(xmit_tick[ch]), int'(e.xmit));
          end
          last[ch] = cyc;
        end else begin
          chk($sformatf("xmit_idle_ch%0d", ch), int'(xmit_tick[ch]), 0);
        end
      end
    end
  end

  task automatic push(input int ch, input int gap);
    exp_t e;
    e.gap   = gap;
    e.phase = ph[ch];
    e.xmit  = (ph[ch] == OVS - 1);
    ph[ch]  = (ph[ch] + 1) % OVS;
    if (ch == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cfg_load = '0;
      sync_clr = '0;
    end
  endtask

  task automatic cfg(input int ch, input int val, input int frac);
    baud_val[ch*CNT_W +: CNT_W]    = val[CNT_W-1:0];
    baud_frac[ch*FRAC_W +: FRAC_W] = frac[FRAC_W-1:0];
    cfg_load[ch] = 1'b1;
  endtask

  task automatic restart(input int ch);
    sync_clr[ch] = 1'b1;
    ph[ch] = 0;
  endtask

  task automatic drain(input string tag);
    chk({tag, "_pending_ch0"}, q0.size(), 0);
    chk({tag, "_pending_ch1"}, q1.size(), 0);
    q0.delete();
    q1.delete();
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_baud_tick"}, int'(baud_tick), 0);
    chk({tag, "_xmit_tick"}, int'(xmit_tick), 0);
    chk({tag, "_ovs_phase"}, int'(ovs_phase), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ph[0] = 0;
    ph[1] = 0;
    reset = 1'b1;
    enable = '0;
    cfg_load = '0;
    sync_clr = '0;
    baud_val = '0;
    baud_frac = '0;
    #1;
    outputs_zero("in_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    outputs_zero("after_release");
    step(1);

    // Integer divide: val=3 -> period 4, xmit on every 10th tick.
    cfg(0, 3, 0); restart(0); enable[0] = 1'b1;
    push(0, 1);
    repeat (20) push(0, 4);
    step(1 + 81);
    enable[0] = 1'b0; step(2); drain("int_div");

    // Fractional divisors.
    cfg(0, 3, 4); restart(0); enable[0] = 1'b1;
    foreach (gap_f4[k]) push(0, gap_f4[k]);
    step(1 + 37);
    enable[0] = 1'b0; step(2); drain("frac4");

    cfg(0, 3, 1); restart(0); enable[0] = 1'b1;
    foreach (gap_f1[k]) push(0, gap_f1[k]);
    step(1 + 38);
    enable[0] = 1'b0; step(2); drain("frac1");

    cfg(0, 3, 7); restart(0); enable[0] = 1'b1;
    foreach (gap_f7[k]) push(0, gap_f7[k]);
    step(1 + 44);
    enable[0] = 1'b0; step(2); drain("frac7");

    // Reload mid-period: old period completes, new one follows.
    cfg(0, 9, 0); restart(0); enable[0] = 1'b1;
    foreach (gap_ld[k]) push(0, gap_ld[k]);
    step(1 + 4);
    cfg(0, 2, 0);
    step(19);
    enable[0] = 1'b0; step(2); drain("reload");

    // Enable low for 7 cycles mid-period stretches it by exactly 7.
    cfg(0, 3, 0); restart(0); enable[0] = 1'b1;
    foreach (gap_en[k]) push(0, gap_en[k]);
    step(1 + 6);
    enable[0] = 1'b0;
    step(7);
    enable[0] = 1'b1;
    step(11);
    enable[0] = 1'b0; step(2); drain("enable");

    // sync_clr mid-run restarts phase; xmit after 10 more ticks.
    cfg(0, 3, 0); restart(0); enable[0] = 1'b1;
    push(0, 1);
    repeat (6) push(0, 4);
    step(1 + 26);
    restart(0);
    push(0, 1);
    repeat (10) push(0, 4);
    step(1);
    chk("clr_phase", int'(ovs_phase[3:0]), 0);
    chk("clr_tick", int'(baud_tick[0]), 0);
    step(41);
    enable[0] = 1'b0; step(2); drain("sync_clr");

    // Independence: ch0 period 2, ch1 val=4 frac=2; ch0 disturbed later.
    cfg(0, 1, 0); cfg(1, 4, 2); restart(0); restart(1); enable = 2'b11;
    push(0, 1);
    repeat (19) push(0, 2);
    foreach (gap_c1[k]) push(1, gap_c1[k]);
    step(1 + 39);
    enable[0] = 1'b0;
    step(6);
    cfg(0, 0, 5); restart(0);
    step(24);
    enable = 2'b00; step(2); drain("indep");

    // Asynchronous reset mid-operation, then zero shadows tick every cycle.
    cfg(0, 3, 0); cfg(1, 0, 0); restart(0); restart(1); enable = 2'b11;
    foreach (gap_c1[k]) if (k < 3) push(0, (k == 0) ? 1 : 4);
    repeat (11) push(1, 1);
    step(1 + 11);
    #2 reset = 1'b1;
    #1;
    outputs_zero("async_reset");
    ph[0] = 0;
    ph[1] = 0;
    foreach (gap_rl[k]) push(0, gap_rl[k]);
    repeat (11) push(1, 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    outputs_zero("post_reset");
    step(3);
    cfg(0, 2, 0);
    step(8);
    enable = 2'b00; step(2); drain("reset");

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
